matrix_alu: RTL and testbench

- Matrix arithmetic unit of the coprocessor datapath.
- Operates on two 5x5 matrices of signed 8-bit elements, packed into 200-bit buses, plus an 8-bit scalar.
- Element-wise, product, transpose and negation ops complete in one clock; determinant runs as a multi-cycle sequence launched by start.
- Fed from the 128x16 MemoryBlock RAM by the coprocessor FSM; the RAM is an existing sibling block and outside this spec.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_det_seq.sv | 117 +++++++++++
 rtl/matrix_alu.sv | 71 +++++++
 tb/tb_matrix_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants for the 5x5 int8 matrix ALU: sizes, opcodes, determinant states.
// Pure definitions; no latency or flow control.
package matrix_pkg;
    localparam int DIM    = 5;
    localparam int EW     = 8;
    localparam int BUS_W  = DIM * DIM * EW;
    localparam int DET_W  = 48;
    localparam int PROD_W = 2 * DET_W;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_SCL  = 3'd3;
    localparam logic [2:0] OP_TRN  = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;
    localparam logic [2:0] OP_DET  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {DET_IDLE, DET_PIVOT, DET_ELIM, DET_DONE} det_state_t;

    // Sign-extended element (r,c) of a packed matrix bus.
    function automatic int elem(input logic [BUS_W-1:0] bus, input int r, input int c);
        return int'($signed(bus[EW*(DIM*r+c) +: EW]));
    endfunction
endpackage

// File: rtl/matrix_det_seq.sv
// Bareiss determinant engine on a 48-bit copy of A; launched by a rising edge of start.
// Latency: 1 + 4 pivots + 10 row steps + 1 done cycle; start while busy is ignored.
module matrix_det_seq
    import matrix_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BUS_W-1:0]        matrix_a,
    output logic                    busy,
    output logic                    done,
    output logic signed [DET_W-1:0] det
);
    det_state_t state_q, state_d;
    logic signed [DET_W-1:0] a [DIM][DIM];
    logic signed [DET_W-1:0] prev;
    logic signed [DET_W-1:0] elim_row [DIM];
    logic [2:0] k, row, piv_row;
    logic       neg, zero, start_q, launch, piv_found, pivot_ok, last_row;

    assign launch   = start && !start_q && (state_q == DET_IDLE);
    assign pivot_ok = (a[k][k] != '0);
    assign last_row = (row == 3'(DIM-1));

    always_comb begin
        piv_found = 1'b0;
        piv_row   = k;
        for (int r = 1; r < DIM; r++) begin
            if (!piv_found && (3'(r) > k) && (a[r][k] != '0)) begin
                piv_found = 1'b1;
                piv_row   = 3'(r);
            end
        end
    end

    // Products reach ~2^64 before the exact division by the previous pivot.
    always_comb begin
        for (int j = 0; j < DIM; j++) begin
            elim_row[j] = DET_W'((PROD_W'(a[k][k]) * PROD_W'(a[row][j])
                                - PROD_W'(a[row][k]) * PROD_W'(a[k][j])) / PROD_W'(prev));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= DET_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_IDLE:  if (launch) state_d = DET_PIVOT;
            DET_PIVOT: state_d = (!pivot_ok && !piv_found) ? DET_DONE : DET_ELIM;
            DET_ELIM:  if (last_row) state_d = (k == 3'(DIM-2)) ? DET_DONE : DET_PIVOT;
            DET_DONE:  state_d = DET_IDLE;
            default:   state_d = DET_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != DET_IDLE);
        done = (state_q == DET_DONE);
        det  = zero ? '0 : (neg ? -a[DIM-1][DIM-1] : a[DIM-1][DIM-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            k       <= '0;
            row     <= '0;
            prev    <= DET_W'(1);
            neg     <= 1'b0;
            zero    <= 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    a[r][c] <= '0;
        end else begin
            start_q <= start;
            case (state_q)
                DET_IDLE: if (launch) begin
                    k    <= '0;
                    prev <= DET_W'(1);
                    neg  <= 1'b0;
                    zero <= 1'b0;
                    for (int r = 0; r < DIM; r++)
                        for (int c = 0; c < DIM; c++)
                            a[r][c] <= DET_W'(elem(matrix_a, r, c));
                end
                DET_PIVOT: begin
                    row <= k + 3'd1;
                    if (!pivot_ok) begin
                        if (piv_found) begin
                            neg <= ~neg;
                            for (int j = 0; j < DIM; j++) begin
                                a[k][j]       <= a[piv_row][j];
                                a[piv_row][j] <= a[k][j];
                            end
                        end else begin
                            zero <= 1'b1;
                        end
                    end
                end
                DET_ELIM: begin
                    for (int j = 0; j < DIM; j++)
                        a[row][j] <= elim_row[j];
                    if (last_row) begin
                        prev <= a[k][k];
                        k    <= k + 3'd1;
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/matrix_alu.sv
// 5x5 int8 matrix ALU: element-wise, product, scalar, transpose, negate, determinant.
// Latency: 1 cycle for ops 0-5; determinant via matrix_det_seq; no backpressure.
module matrix_alu
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op_code,
    input  logic [BUS_W-1:0] matrix_a,
    input  logic [BUS_W-1:0] matrix_b,
    input  logic [EW-1:0]    scalar,
    input  logic             start,
    output logic [BUS_W-1:0] result_final,
    output logic             overflow
);
    logic                    det_busy, det_done;
    logic signed [DET_W-1:0] det_val, det_store;
    logic [BUS_W-1:0]        nxt_res;
    logic                    nxt_ovf;

    matrix_det_seq u_det (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .matrix_a (matrix_a),
        .busy     (det_busy),
        .done     (det_done),
        .det      (det_val)
    );

    // Every element is computed exactly in an int, then wrapped to 8 bits.
    always_comb begin
        nxt_res = '0;
        nxt_ovf = 1'b0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                int val;
                val = 0;
                case (op_code)
                    OP_ADD: val = elem(matrix_a, r, c) + elem(matrix_b, r, c);
                    OP_SUB: val = elem(matrix_a, r, c) - elem(matrix_b, r, c);
                    OP_MUL: for (int m = 0; m < DIM; m++)
                                val += elem(matrix_a, r, m) * elem(matrix_b, m, c);
                    OP_SCL: val = int'($signed(scalar)) * elem(matrix_a, r, c);
                    OP_TRN: val = elem(matrix_a, c, r);
                    OP_NEG: val = -elem(matrix_a, r, c);
                    OP_DET, OP_RSVD: val = 0;
                endcase
                nxt_res[EW*(DIM*r+c) +: EW] = val[EW-1:0];
                if (val < -128 || val > 127) nxt_ovf = 1'b1;
            end
        end
        if (op_code == OP_DET) begin
            nxt_res          = '0;
            nxt_res[EW-1:0]  = det_store[EW-1:0];
            nxt_ovf          = (det_store < -48'sd128) || (det_store > 48'sd127);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_final <= '0;
            overflow     <= 1'b0;
            det_store    <= '0;
        end else begin
            result_final <= nxt_res;
            overflow     <= nxt_ovf;
            if (det_done && det_busy) det_store <= det_val;
        end
    end
endmodule

// File: tb/tb_matrix_alu.sv
// Directed bench for matrix_alu with hand-computed expectations.
module tb_matrix_alu;
    import matrix_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       op_code = 3'd0;
    logic [BUS_W-1:0] matrix_a = '0;
    logic [BUS_W-1:0] matrix_b = '0;
    logic [EW-1:0]    scalar = '0;
    logic             start = 1'b0;
    logic [BUS_W-1:0] result_final;
    logic             overflow;
    int               checks = 0;
    int               failures = 0;

    matrix_alu dut (
        .clk          (clk),
        .reset        (reset),
        .op_code      (op_code),
        .matrix_a     (matrix_a),
        .matrix_b     (matrix_b),
        .scalar       (scalar),
        .start        (start),
        .result_final (result_final),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] el(input int i);
        return result_final[EW*i +: EW];
    endfunction

    function automatic logic [BUS_W-1:0] fill_seq(input int base, input int inc);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIM*DIM; i++) m[EW*i +: EW] = 8'(base + inc*i);
        return m;
    endfunction

    function automatic logic [BUS_W-1:0] diag(input logic [EW-1:0] v);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIM; i++) m[EW*(DIM*i+i) +: EW] = v;
        return m;
    endfunction

    task automatic run_det(input logic [BUS_W-1:0] m);
        matrix_a = m;
        op_code  = OP_DET;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        step(64);
    endtask

    initial begin
        logic [BUS_W-1:0] perm;
        perm = diag(8'd1);
        perm[EW*0 +: EW] = 8'd0;
        perm[EW*6 +: EW] = 8'd0;
        perm[EW*1 +: EW] = 8'd1;
        perm[EW*5 +: EW] = 8'd1;

        step(2);
        chk("reset_res", result_final, '0);
        chk("reset_ovf", BUS_W'(overflow), '0);
        reset = 1'b1;

        matrix_a = fill_seq(1, 1);
        matrix_b = fill_seq(1, 0);
        scalar   = 8'd3;

        op_code = OP_ADD; step(1);
        chk("add_e0", BUS_W'(el(0)), BUS_W'(8'd2));
        chk("add_e24", BUS_W'(el(24)), BUS_W'(8'd26));
        chk("add_ovf", BUS_W'(overflow), '0);

        op_code = OP_SUB; step(1);
        chk("sub_e0", BUS_W'(el(0)), '0);
        chk("sub_e24", BUS_W'(el(24)), BUS_W'(8'd24));

        op_code = OP_MUL; step(1);
        for (int i = 0; i < DIM*DIM; i++)
            chk($sformatf("mul_e%0d", i), BUS_W'(el(i)), BUS_W'(8'(25*(i/5) + 15)));
        chk("mul_ovf", BUS_W'(overflow), '0);

        op_code = OP_SCL; step(1);
        chk("scl_e24", BUS_W'(el(24)), BUS_W'(8'd75));
        chk("scl_ovf", BUS_W'(overflow), '0);

        op_code = OP_TRN; step(1);
        chk("trn_e1", BUS_W'(el(1)), BUS_W'(8'd6));
        chk("trn_e5", BUS_W'(el(5)), BUS_W'(8'd2));
        chk("trn_e24", BUS_W'(el(24)), BUS_W'(8'd25));
        chk("trn_ovf", BUS_W'(overflow), '0);

        op_code = OP_NEG; step(1);
        chk("neg_e0", BUS_W'(el(0)), BUS_W'(8'hFF));
        chk("neg_ovf", BUS_W'(overflow), '0);

        op_code = OP_RSVD; step(1);
        chk("rsvd_res", result_final, '0);
        chk("rsvd_ovf", BUS_W'(overflow), '0);

        matrix_a = fill_seq(100, 0);
        matrix_b = fill_seq(100, 0);
        op_code  = OP_ADD; step(1);
        chk("sat_e0", BUS_W'(el(0)), BUS_W'(8'hC8));
        chk("sat_e24", BUS_W'(el(24)), BUS_W'(8'hC8));
        chk("sat_ovf", BUS_W'(overflow), BUS_W'(1'b1));

        run_det(fill_seq(1, 1));
        chk("det_seq", result_final, '0);
        chk("det_seq_ovf", BUS_W'(overflow), '0);

        run_det(diag(8'd2));
        chk("det_diag2", result_final, BUS_W'(8'd32));
        chk("det_diag2_ovf", BUS_W'(overflow), '0);

        run_det(diag(8'd3));
        chk("det_diag3", result_final, BUS_W'(8'hF3));
        chk("det_diag3_ovf", BUS_W'(overflow), BUS_W'(1'b1));

        run_det(perm);
        chk("det_perm", result_final, BUS_W'(8'hFF));
        chk("det_perm_ovf", BUS_W'(overflow), '0);

        // Launch under another opcode, switch to det mid-run.
        matrix_a = diag(8'd2);
        op_code  = OP_ADD;
        start    = 1'b1; step(1);
        start    = 1'b0; step(3);
        op_code  = OP_DET; step(60);
        chk("det_opchg", result_final, BUS_W'(8'd32));

        // Held start must not relaunch with the later A.
        matrix_a = perm;
        start    = 1'b1; step(30);
        matrix_a = diag(8'd3); step(40);
        chk("det_held", result_final, BUS_W'(8'hFF));
        start = 1'b0; step(2);

        matrix_a = diag(8'd2);
        start    = 1'b1; step(1);
        start    = 1'b0; step(5);
        reset    = 1'b0; #1;
        chk("midrst_res", result_final, '0);
        chk("midrst_ovf", BUS_W'(overflow), '0);
        step(2);
        reset = 1'b1; step(2);
        chk("midrst_cleared", result_final, '0);

        run_det(diag(8'd3));
        chk("det_after_rst", result_final, BUS_W'(8'hF3));
        chk("det_after_rst_ovf", BUS_W'(overflow), BUS_W'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
